// File: rtl/cascade_iir_low_pass_filter.sv
// Cascade of first-order IIR (exponential moving average) low-pass stages.
// Each stage computes y += (x - y) >>> shift with extended internal precision.
// The output is rounded half-up, saturated and registered. A settle counter
// reports when the cascade has had time to converge for the current coefficient.
module cascade_iir_low_pass_filter #(
  parameter int num_stages   = 8,
  parameter int data_width   = 16,
  parameter int guard_bits   = 8,
  parameter int shift_width  = 4,
  parameter int settle_width = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [num_stages-1:0]        stage_enable,
  input  logic [shift_width-1:0]       shift,
  input  logic                         clear,
  input  logic signed [data_width-1:0] sample_in,
  input  logic                         sample_in_valid,
  output logic signed [data_width-1:0] sample_out,
  output logic                         sample_out_valid,
  output logic                         settled
);

  localparam int W    = data_width + guard_bits;
  localparam int LAST = num_stages - 1;

  // Half an output LSB at internal scale, used for round-half-up.
  localparam logic signed [W:0] ROUND_HALF = $signed((W + 1)'(1) << (guard_bits - 1));
  // Largest positive output value expressed in W+1 bits.
  localparam logic signed [W:0] OUT_MAX =
    $signed({{(guard_bits + 2){1'b0}}, {(data_width - 1){1'b1}}});

  logic signed [W-1:0]       x0;
  logic signed [W-1:0]       acc      [num_stages];
  logic signed [W-1:0]       stage_in [num_stages];
  logic signed [W-1:0]       acc_next [num_stages];
  logic [num_stages-1:0]     v;
  logic [num_stages-1:0]     stage_vin;

  logic signed [W:0]         rnd_full;
  logic signed [W:0]         rnd_sh;
  logic signed [data_width-1:0] out_sat;

  logic [num_stages-1:0]     prev_enable;
  logic [shift_width-1:0]    prev_shift;
  logic                      cfg_changed;
  logic [settle_width-1:0]   settle_cnt;
  logic [settle_width-1:0]   cnt_next;
  logic [settle_width-1:0]   settle_thresh;

  // Sign-extend to W bits and scale up by the guard bits.
  assign x0 = {sample_in, {guard_bits{1'b0}}};

  // Chain each stage's input sample and valid from the previous stage.
  always_comb begin
    stage_in  = '{default: '0};
    stage_vin = '0;
    stage_in[0]  = x0;
    stage_vin[0] = sample_in_valid;
    for (int unsigned i = 1; i < num_stages; i++) begin
      stage_in[i]  = acc[i-1];
      stage_vin[i] = v[i-1];
    end
  end

  // Next accumulator value per stage: EMA update when enabled, load input when disabled.
  always_comb begin : stage_math
    logic signed [W:0] diff;
    logic signed [W:0] step;
    logic signed [W:0] sum;
    diff     = '0;
    step     = '0;
    sum      = '0;
    acc_next = '{default: '0};
    for (int unsigned i = 0; i < num_stages; i++) begin
      diff = $signed({stage_in[i][W-1], stage_in[i]}) - $signed({acc[i][W-1], acc[i]});
      step = diff >>> shift;
      // The result always lies between acc and the input, so dropping the top bit is exact.
      sum  = $signed({acc[i][W-1], acc[i]}) + step;
      acc_next[i] = stage_enable[i] ? W'(sum) : stage_in[i];
    end
  end

  // Round half up and saturate the value the last stage is about to take.
  // Working from acc_next keeps the total latency at num_stages cycles.
  always_comb begin
    rnd_full = $signed({acc_next[LAST][W-1], acc_next[LAST]}) + ROUND_HALF;
    rnd_sh   = rnd_full >>> guard_bits;
    out_sat  = (rnd_sh > OUT_MAX) ? data_width'(OUT_MAX) : data_width'(rnd_sh);
  end

  // Stage accumulators and valid pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < num_stages; i++) acc[i] <= '0;
      v <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < num_stages; i++) acc[i] <= '0;
      v <= '0;
    end else begin
      v <= stage_vin;
      for (int unsigned i = 0; i < num_stages; i++) begin
        if (stage_vin[i]) acc[i] <= acc_next[i];
      end
    end
  end

  assign sample_out_valid = v[LAST];

  // Registered output sample, held between valid pulses and across clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_out <= '0;
    end else if (stage_vin[LAST] && !clear) begin
      sample_out <= out_sat;
    end
  end

  // Settle counter next state and convergence threshold.
  always_comb begin
    cfg_changed   = (stage_enable != prev_enable) || (shift != prev_shift);
    settle_thresh = settle_width'(num_stages + 1) << shift;
    cnt_next      = settle_cnt;
    if (clear || cfg_changed) begin
      cnt_next = '0;
    end else if (sample_out_valid && (settle_cnt != '1)) begin
      cnt_next = settle_cnt + 1'b1;
    end
  end

  // Configuration history, settle counter and settled flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_enable <= '0;
      prev_shift  <= '0;
      settle_cnt  <= '0;
      settled     <= 1'b0;
    end else begin
      prev_enable <= stage_enable;
      prev_shift  <= shift;
      settle_cnt  <= cnt_next;
      settled     <= (cnt_next >= settle_thresh);
    end
  end

endmodule

// File: tb/tb_cascade_iir_low_pass_filter.sv
// Directed self-checking bench for cascade_iir_low_pass_filter.
module tb_cascade_iir_low_pass_filter;

  localparam int NS  = 8;
  localparam int DW  = 16;
  localparam int GB  = 8;
  localparam int SW  = 4;
  localparam int STW = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NS-1:0]        stage_enable;
  logic [SW-1:0]        shift;
  logic                 clear;
  logic signed [DW-1:0] sample_in;
  logic                 sample_in_valid;
  logic signed [DW-1:0] sample_out;
  logic                 sample_out_valid;
  logic                 settled;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [DW-1:0] pass_vals [3] = '{16'sd100, -16'sd200, 16'sd32767};
  logic signed [DW-1:0] exp_pos   [4] = '{16'sd500, 16'sd750, 16'sd875, 16'sd938};
  logic signed [DW-1:0] exp_neg   [4] = '{-16'sd500, -16'sd750, -16'sd875, -16'sd937};

  always #5 clk = ~clk;

  cascade_iir_low_pass_filter #(
    .num_stages  (NS),
    .data_width  (DW),
    .guard_bits  (GB),
    .shift_width (SW),
    .settle_width(STW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stage_enable    (stage_enable),
    .shift           (shift),
    .clear           (clear),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
    .settled         (settled)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Program a configuration and flush state in the same cycle.
  task automatic configure(input logic [NS-1:0] en, input logic [SW-1:0] sh);
    step();
    stage_enable    = en;
    shift           = sh;
    clear           = 1'b1;
    sample_in_valid = 1'b0;
    sample_in       = '0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (sample_out !== 16'sd0) begin n_bad++; $display("FAIL reset_out got %0d exp 0", sample_out); end
    n_cmp++; if (sample_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", sample_out_valid); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL reset_settled got %b exp 0", settled); end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    step();
    @(negedge clk);
    n_cmp++; if (sample_out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid got %b exp 0", sample_out_valid); end
  endtask

  task automatic test_passthrough();
    logic exp_v;
    configure('0, 4'd0);
    for (int c = 0; c < 13; c++) begin
      step();
      clear           = 1'b0;
      sample_in_valid = (c < 3);
      sample_in       = (c < 3) ? pass_vals[c] : '0;
      @(negedge clk);
      exp_v = (c >= 8 && c <= 10);
      n_cmp++; if (sample_out_valid !== exp_v) begin n_bad++; $display("FAIL pass_valid c=%0d got %b exp %b", c, sample_out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (sample_out !== pass_vals[c-8]) begin n_bad++; $display("FAIL pass_value c=%0d got %0d exp %0d", c, sample_out, pass_vals[c-8]); end
      end
    end
  endtask

  task automatic test_single_stage();
    logic exp_v;
    configure(8'h01, 4'd1);
    for (int c = 0; c < 14; c++) begin
      step();
      clear           = 1'b0;
      sample_in_valid = (c < 4);
      sample_in       = 16'sd1000;
      @(negedge clk);
      exp_v = (c >= 8 && c <= 11);
      n_cmp++; if (sample_out_valid !== exp_v) begin n_bad++; $display("FAIL step_pos_valid c=%0d got %b exp %b", c, sample_out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (sample_out !== exp_pos[c-8]) begin n_bad++; $display("FAIL step_pos_value c=%0d got %0d exp %0d", c, sample_out, exp_pos[c-8]); end
      end
    end
    step();
    sample_in_valid = 1'b0;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      sample_in_valid = (c < 4);
      sample_in       = -16'sd1000;
      @(negedge clk);
      exp_v = (c >= 8 && c <= 11);
      n_cmp++; if (sample_out_valid !== exp_v) begin n_bad++; $display("FAIL step_neg_valid c=%0d got %b exp %b", c, sample_out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (sample_out !== exp_neg[c-8]) begin n_bad++; $display("FAIL step_neg_value c=%0d got %0d exp %0d", c, sample_out, exp_neg[c-8]); end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] prev;
    int pulses;
    logic exp_v;
    prev   = '0;
    pulses = 0;
    configure('1, 4'd2);
    for (int c = 0; c < 210; c++) begin
      step();
      clear           = 1'b0;
      sample_in_valid = (c < 200);
      sample_in       = 16'sd32767;
      @(negedge clk);
      exp_v = (c >= 8 && c < 208);
      n_cmp++; if (sample_out_valid !== exp_v) begin n_bad++; $display("FAIL sat_valid c=%0d got %b exp %b", c, sample_out_valid, exp_v); end
      if (sample_out_valid) begin
        pulses++;
        n_cmp++; if (sample_out < prev) begin n_bad++; $display("FAIL sat_monotonic c=%0d got %0d exp >= %0d", c, sample_out, prev); end
        prev = sample_out;
        if (pulses == 200) begin
          n_cmp++; if (sample_out !== 16'sd32767) begin n_bad++; $display("FAIL sat_final got %0d exp 32767", sample_out); end
        end
      end
    end
    n_cmp++; if (pulses != 200) begin n_bad++; $display("FAIL sat_count got %0d exp 200", pulses); end
  endtask

  task automatic test_settle();
    int k;
    k = 0;
    configure(8'h01, 4'd0);
    for (int c = 0; c < 29; c++) begin
      step();
      clear           = 1'b0;
      sample_in_valid = (c < 20);
      sample_in       = 16'sd50;
      @(negedge clk);
      if (sample_out_valid) begin
        k++;
        n_cmp++; if (settled !== (k >= 10)) begin n_bad++; $display("FAIL settle0 pulse=%0d got %b exp %b", k, settled, (k >= 10)); end
        n_cmp++; if (sample_out !== 16'sd50) begin n_bad++; $display("FAIL settle0_value pulse=%0d got %0d exp 50", k, sample_out); end
      end
    end
    n_cmp++; if (k != 20) begin n_bad++; $display("FAIL settle0_count got %0d exp 20", k); end
    step();
    shift = 4'd1;
    @(negedge clk);
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL settle_before_change got %b exp 1", settled); end
    step();
    @(negedge clk);
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL settle_drop got %b exp 0", settled); end
    k = 0;
    for (int c = 0; c < 29; c++) begin
      step();
      sample_in_valid = (c < 20);
      sample_in       = 16'sd50;
      @(negedge clk);
      if (sample_out_valid) begin
        k++;
        n_cmp++; if (settled !== (k >= 19)) begin n_bad++; $display("FAIL settle1 pulse=%0d got %b exp %b", k, settled, (k >= 19)); end
        n_cmp++; if (sample_out !== 16'sd50) begin n_bad++; $display("FAIL settle1_value pulse=%0d got %0d exp 50", k, sample_out); end
      end
    end
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL settle1_final got %b exp 1", settled); end
  endtask

  task automatic test_clear_midstream();
    configure(8'h01, 4'd1);
    for (int c = 0; c < 43; c++) begin
      step();
      clear           = (c == 30);
      sample_in_valid = (c <= 40);
      sample_in       = 16'sd1000;
      @(negedge clk);
      if (c >= 8 && c <= 30) begin
        n_cmp++; if (sample_out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_pre_valid c=%0d got %b exp 1", c, sample_out_valid); end
      end
      if (c == 30) begin
        n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL clr_pre_settled got %b exp 1", settled); end
      end
      if (c == 31) begin
        n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL clr_settled got %b exp 0", settled); end
        n_cmp++; if (sample_out !== 16'sd1000) begin n_bad++; $display("FAIL clr_hold got %0d exp 1000", sample_out); end
      end
      if (c >= 31 && c <= 38) begin
        n_cmp++; if (sample_out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_gap_valid c=%0d got %b exp 0", c, sample_out_valid); end
      end
      if (c >= 39) begin
        n_cmp++; if (sample_out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_post_valid c=%0d got %b exp 1", c, sample_out_valid); end
        n_cmp++; if (sample_out !== exp_pos[c-39]) begin n_bad++; $display("FAIL clr_post_value c=%0d got %0d exp %0d", c, sample_out, exp_pos[c-39]); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic exp_v;
    configure(8'h01, 4'd1);
    for (int c = 0; c < 11; c++) begin
      step();
      clear           = 1'b0;
      sample_in_valid = (c < 8);
      sample_in       = 16'sd1000;
      @(negedge clk);
      if (c >= 8) begin
        n_cmp++; if (sample_out !== exp_pos[c-8]) begin n_bad++; $display("FAIL ar_pre_value c=%0d got %0d exp %0d", c, sample_out, exp_pos[c-8]); end
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (sample_out !== 16'sd0) begin n_bad++; $display("FAIL ar_out got %0d exp 0", sample_out); end
    n_cmp++; if (sample_out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid got %b exp 0", sample_out_valid); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL ar_settled got %b exp 0", settled); end
    sample_in_valid = 1'b0;
    #4;
    rst = 1'b1;
    for (int c = 0; c < 13; c++) begin
      step();
      sample_in_valid = (c < 4);
      sample_in       = 16'sd1000;
      @(negedge clk);
      exp_v = (c >= 8 && c <= 11);
      n_cmp++; if (sample_out_valid !== exp_v) begin n_bad++; $display("FAIL ar_post_valid c=%0d got %b exp %b", c, sample_out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (sample_out !== exp_pos[c-8]) begin n_bad++; $display("FAIL ar_post_value c=%0d got %0d exp %0d", c, sample_out, exp_pos[c-8]); end
      end
    end
  endtask

  initial begin
    rst             = 1'b0;
    stage_enable    = '0;
    shift           = '0;
    clear           = 1'b0;
    sample_in       = '0;
    sample_in_valid = 1'b0;
    test_reset();
    test_passthrough();
    test_single_stage();
    test_saturation();
    test_settle();
    test_clear_midstream();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
